// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: load/store over a req/ack bus, pass-through for non-memory ops
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUS} state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  ld_wd_q, ld_wd_d;
  logic        ld_wreg_q, ld_wreg_d;
  logic        flushed_q, flushed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;

  logic        is_mem, is_store, aligned, live, kill;
  logic [3:0]  issue_sel;
  logic [31:0] issue_wdata;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  // Decode of the incoming instruction: lanes are big-endian (addr 0 -> bits 31:24)
  always_comb begin
    is_mem      = 1'b0;
    is_store    = 1'b0;
    aligned     = 1'b1;
    issue_sel   = 4'b1111;
    issue_wdata = reg2_i;
    case (aluop_i)
      OP_LB, OP_LBU, OP_SB: begin
        is_mem      = 1'b1;
        is_store    = (aluop_i == OP_SB);
        issue_sel   = 4'b1000 >> mem_addr_i[1:0];
        issue_wdata = {4{reg2_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_mem      = 1'b1;
        is_store    = (aluop_i == OP_SH);
        aligned     = ~mem_addr_i[0];
        issue_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        issue_wdata = {2{reg2_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        is_mem   = 1'b1;
        is_store = (aluop_i == OP_SW);
        aligned  = (mem_addr_i[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = bus_rdata_i;
    case (off_q)
      2'b00:   byte_v = bus_rdata_i[31:24];
      2'b01:   byte_v = bus_rdata_i[23:16];
      2'b10:   byte_v = bus_rdata_i[15:8];
      default: byte_v = bus_rdata_i[7:0];
    endcase
    half_v = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h0, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0, half_v};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    ld_wd_d     = ld_wd_q;
    ld_wreg_d   = ld_wreg_q;
    flushed_d   = flushed_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    wd_d        = wd_q;
    wreg_d      = 1'b0;
    wdata_d     = wdata_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    stallreq_o  = 1'b0;
    live        = valid_i & ~flush_i;
    kill        = flushed_q | flush_i;

    case (state_q)
      IDLE: begin
        wd_d    = wd_i;
        wdata_d = wdata_i;
        if (live && is_mem && aligned) begin
          stallreq_o  = 1'b1;
          state_d     = BUS;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_sel_d   = issue_sel;
          bus_wdata_d = issue_wdata;
          op_d        = aluop_i;
          off_d       = mem_addr_i[1:0];
          ld_wd_d     = wd_i;
          ld_wreg_d   = wreg_i;
          flushed_d   = 1'b0;
          cnt_d       = 8'd0;
        end else if (live && is_mem) begin
          valid_d     = 1'b1;
          align_err_d = 1'b1;
          wdata_d     = 32'h0;
        end else begin
          valid_d = live;
          wreg_d  = wreg_i & live;
        end
      end
      BUS: begin
        stallreq_o = ~bus_ack_i;
        if (flush_i) flushed_d = 1'b1;
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          valid_d   = ~kill;
          wd_d      = ld_wd_q;
          wreg_d    = ~kill & ~bus_we_q & ld_wreg_q;
          wdata_d   = bus_we_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: report an error result that retires without writing a register
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          bus_err_d = 1'b1;
          valid_d   = ~kill;
          wd_d      = ld_wd_q;
          wdata_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= 32'h0;
      op_q        <= 8'h0;
      off_q       <= 2'b00;
      ld_wd_q     <= 5'd0;
      ld_wreg_q   <= 1'b0;
      flushed_q   <= 1'b0;
      cnt_q       <= 8'd0;
      valid_q     <= 1'b0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      wdata_q     <= 32'h0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
      ld_wd_q     <= ld_wd_d;
      ld_wreg_q   <= ld_wreg_d;
      flushed_q   <= flushed_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign align_err_o = align_err_q;
  assign bus_err_o   = bus_err_q;

endmodule
